// File: rtl/video_stream_if.sv
// Control and pixel-stream bundle between the synthetic video source and its consumer.
// The master side is the generator: it takes enable/pattern_sel and drives the stream.
interface video_stream_if;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_de;
    logic [7:0]  per_img_Y;
    logic        frame_done;
    logic [15:0] frame_cnt;

    modport master (
        input  enable, pattern_sel,
        output per_frame_vsync, per_frame_href, per_frame_de, per_img_Y,
               frame_done, frame_cnt
    );

    modport slave (
        output enable, pattern_sel,
        input  per_frame_vsync, per_frame_href, per_frame_de, per_img_Y,
               frame_done, frame_cnt
    );
endinterface

// File: rtl/video_stream_gen.sv
// Synthetic grey video source: vsync / back porch / active lines with h-blank,
// four test patterns, registered outputs driven from the next-state values.
module video_stream_gen #(
    parameter logic [9:0]  IMG_HDISP  = 10'd100,
    parameter logic [9:0]  IMG_VDISP  = 10'd100,
    parameter logic [15:0] H_BLANK    = 16'd20,
    parameter logic [15:0] V_SYNC_CYC = 16'd300,
    parameter logic [15:0] V_BACK_CYC = 16'd300,
    parameter logic [7:0]  GRAY_LEVEL = 8'd128
) (
    input logic            clk,
    input logic            rst_n,
    video_stream_if.master vs
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VSYNC  = 3'd1;
    localparam logic [2:0] ST_VBACK  = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_HBLANK = 3'd4;

    logic [2:0]  state_reg, state_next;
    logic [15:0] blank_reg, blank_next;
    logic [9:0]  x_reg, x_next;
    logic [9:0]  y_reg, y_next;
    logic [1:0]  pat_reg, pat_next;
    logic [7:0]  pix_next;
    logic        done_next;

    logic        vsync_reg;
    logic        de_reg;
    logic [7:0]  y_out_reg;
    logic        done_reg;
    logic [15:0] frame_cnt_reg;

    always_comb begin
        state_next = state_reg;
        blank_next = blank_reg + 16'd1;
        x_next     = x_reg;
        y_next     = y_reg;
        pat_next   = pat_reg;
        case (state_reg)
            ST_IDLE: begin
                blank_next = 16'd0;
                if (vs.enable) begin
                    state_next = ST_VSYNC;
                    pat_next   = vs.pattern_sel;
                end
            end
            ST_VSYNC: begin
                if (blank_reg == V_SYNC_CYC - 16'd1) begin
                    state_next = ST_VBACK;
                    blank_next = 16'd0;
                end
            end
            ST_VBACK: begin
                if (blank_reg == V_BACK_CYC - 16'd1) begin
                    state_next = ST_ACTIVE;
                    blank_next = 16'd0;
                    x_next     = 10'd0;
                    y_next     = 10'd0;
                end
            end
            ST_ACTIVE: begin
                blank_next = 16'd0;
                x_next     = x_reg + 10'd1;
                if (x_reg == IMG_HDISP - 10'd1) begin
                    state_next = ST_HBLANK;
                    x_next     = 10'd0;
                end
            end
            ST_HBLANK: begin
                if (blank_reg == H_BLANK - 16'd1) begin
                    blank_next = 16'd0;
                    if (y_reg != IMG_VDISP - 10'd1) begin
                        state_next = ST_ACTIVE;
                        x_next     = 10'd0;
                        y_next     = y_reg + 10'd1;
                    end else if (vs.enable) begin
                        // Back-to-back frame: pattern is re-latched here too
                        state_next = ST_VSYNC;
                        pat_next   = vs.pattern_sel;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                blank_next = 16'd0;
            end
        endcase
    end

    always_comb begin
        case (pat_next)
            2'd0:    pix_next = x_next[7:0];
            2'd1:    pix_next = y_next[7:0];
            2'd2:    pix_next = (x_next[3] ^ y_next[3]) ? 8'hFF : 8'h00;
            default: pix_next = GRAY_LEVEL;
        endcase
    end

    // End of the last active line: first HBLANK cycle of line IMG_VDISP-1
    assign done_next = (state_reg == ST_ACTIVE) && (state_next == ST_HBLANK) &&
                       (y_reg == IMG_VDISP - 10'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            blank_reg     <= 16'd0;
            x_reg         <= 10'd0;
            y_reg         <= 10'd0;
            pat_reg       <= 2'd0;
            vsync_reg     <= 1'b0;
            de_reg        <= 1'b0;
            y_out_reg     <= 8'd0;
            done_reg      <= 1'b0;
            frame_cnt_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            blank_reg     <= blank_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            pat_reg       <= pat_next;
            vsync_reg     <= (state_next == ST_VSYNC);
            de_reg        <= (state_next == ST_ACTIVE);
            y_out_reg     <= (state_next == ST_ACTIVE) ? pix_next : 8'd0;
            done_reg      <= done_next;
            if (done_next)
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign vs.per_frame_vsync = vsync_reg;
    assign vs.per_frame_href  = de_reg;
    assign vs.per_frame_de    = de_reg;
    assign vs.per_img_Y       = y_out_reg;
    assign vs.frame_done      = done_reg;
    assign vs.frame_cnt       = frame_cnt_reg;
endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen: default-size instance for timing/reset
// behaviour and a 16x16 instance for checker/constant patterns.
module tb_video_stream_gen;
    logic clk;
    logic rst_n;

    video_stream_if vif_a();
    video_stream_if vif_b();

    video_stream_gen dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .vs    (vif_a)
    );

    video_stream_gen #(
        .IMG_HDISP  (10'd16),
        .IMG_VDISP  (10'd16),
        .H_BLANK    (16'd4),
        .V_SYNC_CYC (16'd10),
        .V_BACK_CYC (16'd10),
        .GRAY_LEVEL (8'd128)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .vs    (vif_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- monitor for instance A ----------------
    int          cyc = 0;
    logic        vs_prev = 1'b0, de_prev = 1'b0;
    int          nframe = 0;
    int          rise_t [0:7];
    int          rise_last = 0, fall_t = 0;
    int          vs_len = 0, gap = 0;
    int          lines = 0, px = 0;
    int          bad_line = 0, bad_y = 0, busy = 0, fd_cnt = 0, hd_bad = 0;
    logic [7:0]  cap_a [0:7][0:9999];

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        vs_prev <= vif_a.per_frame_vsync;
        de_prev <= vif_a.per_frame_de;
        if (vif_a.per_frame_vsync && !vs_prev) begin
            if (nframe < 8) rise_t[nframe] <= cyc;
            nframe    <= nframe + 1;
            rise_last <= cyc;
            lines     <= 0;
        end
        if (!vif_a.per_frame_vsync && vs_prev) begin
            vs_len <= cyc - rise_last;
            fall_t <= cyc;
        end
        if (vif_a.per_frame_de) begin
            if (!de_prev && lines == 0) gap <= cyc - fall_t;
            if (nframe >= 1 && nframe <= 8 && lines < 100 && px < 100)
                cap_a[nframe-1][lines*100 + px] <= vif_a.per_img_Y;
            px <= px + 1;
        end else if (de_prev) begin
            if (px != 100) bad_line <= bad_line + 1;
            px    <= 0;
            lines <= lines + 1;
        end
        if (!vif_a.per_frame_de && vif_a.per_img_Y != 8'd0) bad_y <= bad_y + 1;
        if (vif_a.per_frame_vsync || vif_a.per_frame_de || vif_a.per_img_Y != 8'd0 ||
            vif_a.frame_done)
            busy <= busy + 1;
        if (vif_a.frame_done) fd_cnt <= fd_cnt + 1;
        if (vif_a.per_frame_href != vif_a.per_frame_de) hd_bad <= hd_bad + 1;
    end

    // ---------------- monitor for instance B ----------------
    logic       bde_prev = 1'b0;
    int         bfr = 0, bl = 0, bpx = 0;
    logic [7:0] cap_b [0:1][0:255];

    always @(negedge clk) begin
        bde_prev <= vif_b.per_frame_de;
        if (vif_b.per_frame_vsync) bl <= 0;
        if (vif_b.per_frame_de) begin
            if (bfr < 2 && bl < 16 && bpx < 16) cap_b[bfr][bl*16 + bpx] <= vif_b.per_img_Y;
            bpx <= bpx + 1;
        end else if (bde_prev) begin
            bpx <= 0;
            bl  <= bl + 1;
        end
        if (vif_b.frame_done) bfr <= bfr + 1;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_cnt_a(input int target, input int budget, input string nm);
        int n = 0;
        while (int'(vif_a.frame_cnt) != target && n < budget) begin
            tick();
            n++;
        end
        check(nm, int'(vif_a.frame_cnt), target);
    endtask

    typedef struct {
        int         dut;   // 0 = default instance, 1 = 16x16 instance
        int         tag;   // which captured frame
        int         x;
        int         y;
        logic [7:0] exp;
    } pix_vec_t;

    pix_vec_t vec [0:19];
    int       fmap [0:3];

    initial begin
        int n, f, b0, b1, b2, b3, bad;

        vec[0]  = '{0, 0,  0,  0, 8'd0};
        vec[1]  = '{0, 0, 99,  0, 8'd99};
        vec[2]  = '{0, 0, 50, 37, 8'd50};
        vec[3]  = '{0, 0, 99, 99, 8'd99};
        vec[4]  = '{0, 1, 17,  3, 8'd17};
        vec[5]  = '{0, 2, 99, 60, 8'd99};
        vec[6]  = '{0, 2,  5, 70, 8'd5};
        vec[7]  = '{0, 2, 30, 49, 8'd30};
        vec[8]  = '{0, 3,  0,  7, 8'd7};
        vec[9]  = '{0, 3, 99,  7, 8'd7};
        vec[10] = '{0, 3, 42,  7, 8'd7};
        vec[11] = '{0, 3,  3, 90, 8'd90};
        vec[12] = '{1, 0,  7,  0, 8'h00};
        vec[13] = '{1, 0,  8,  0, 8'hFF};
        vec[14] = '{1, 0,  8,  8, 8'h00};
        vec[15] = '{1, 0,  0,  8, 8'hFF};
        vec[16] = '{1, 0, 15, 15, 8'h00};
        vec[17] = '{1, 0, 12,  3, 8'hFF};
        vec[18] = '{1, 1,  5,  5, 8'd128};
        vec[19] = '{1, 1, 15,  0, 8'd128};

        rst_n = 1'b0;
        vif_a.enable = 1'b0; vif_a.pattern_sel = 2'd0;
        vif_b.enable = 1'b0; vif_b.pattern_sel = 2'd0;
        repeat (3) tick();

        // 1: reset state, then idle for 2000 cycles with enable low
        check("rst_vsync", vif_a.per_frame_vsync, 0);
        check("rst_de", vif_a.per_frame_de, 0);
        check("rst_Y", vif_a.per_img_Y, 0);
        check("rst_cnt", vif_a.frame_cnt, 0);
        rst_n = 1'b1;
        b0 = busy;
        repeat (2000) tick();
        check("idle_busy_cycles", busy - b0, 0);
        check("idle_frame_cnt", vif_a.frame_cnt, 0);
        $display("T1 idle done, cycle %0d", cyc);

        // 2: single-frame pulse, pattern 0
        b0 = fd_cnt; b1 = bad_line; b2 = bad_y;
        fmap[0] = nframe;
        vif_a.enable = 1'b1;
        tick();
        vif_a.enable = 1'b0;
        wait_cnt_a(1, 14000, "t2_frame_cnt");
        repeat (100) tick();
        check("t2_vsync_len", vs_len, 300);
        check("t2_vback_gap", gap, 300);
        check("t2_lines", lines, 100);
        check("t2_bad_lines", bad_line - b1, 0);
        check("t2_frame_done", fd_cnt - b0, 1);
        check("t2_idle_no_new_frame", nframe, fmap[0] + 1);
        check("t2_idle_vsync", vif_a.per_frame_vsync, 0);
        check("t2_bad_y", bad_y - b2, 0);
        bad = 0;
        for (int y = 0; y < 100; y++)
            for (int x = 0; x < 100; x++)
                if (cap_a[fmap[0]][y*100 + x] != 8'(x)) bad++;
        check("t2_hramp_pixels_wrong", bad, 0);
        $display("T2 single frame done, cycle %0d", cyc);

        // 3/4: enable held for three frames; pattern 0 -> 1 mid second frame
        b1 = bad_line; b2 = bad_y; b3 = fd_cnt;
        f = nframe;
        fmap[1] = f; fmap[2] = f + 1; fmap[3] = f + 2;
        vif_a.pattern_sel = 2'd0;
        vif_a.enable = 1'b1;
        n = 0;
        while (!(nframe == f + 2 && lines == 50) && n < 30000) begin
            tick();
            n++;
        end
        check("t3_reach_line50", n < 30000, 1);
        vif_a.pattern_sel = 2'd1;
        wait_cnt_a(4, 30000, "t3_frame_cnt");
        vif_a.enable = 1'b0;
        repeat (100) tick();
        check("t3_period_1_2", rise_t[f+1] - rise_t[f], 12600);
        check("t3_period_2_3", rise_t[f+2] - rise_t[f+1], 12600);
        check("t3_frames_started", nframe - f, 3);
        check("t3_frame_done", fd_cnt - b3, 3);
        check("t3_bad_y", bad_y - b2, 0);
        check("t3_bad_lines", bad_line - b1, 0);
        $display("T3 three frames done, cycle %0d", cyc);

        // 5: 16x16 instance, checker then constant
        vif_b.pattern_sel = 2'd2;
        vif_b.enable = 1'b1;
        tick();
        vif_b.enable = 1'b0;
        n = 0;
        while (vif_b.frame_cnt != 16'd1 && n < 2000) begin tick(); n++; end
        check("t5_b_frame1", vif_b.frame_cnt, 1);
        repeat (10) tick();
        vif_b.pattern_sel = 2'd3;
        vif_b.enable = 1'b1;
        tick();
        vif_b.enable = 1'b0;
        n = 0;
        while (vif_b.frame_cnt != 16'd2 && n < 2000) begin tick(); n++; end
        check("t5_b_frame2", vif_b.frame_cnt, 2);
        repeat (10) tick();
        $display("T5 small-frame patterns done, cycle %0d", cyc);

        // 6: reset mid-line, restart with enable held
        vif_a.pattern_sel = 2'd0;
        vif_a.enable = 1'b1;
        f = nframe;
        n = 0;
        while (!(nframe == f + 1 && vif_a.per_frame_de && lines == 10 && px == 41) && n < 3000) begin
            tick();
            n++;
        end
        check("t6_reach_px40", n < 3000, 1);
        rst_n = 1'b0;
        #1;
        check("t6_async_vsync", vif_a.per_frame_vsync, 0);
        check("t6_async_de", vif_a.per_frame_de, 0);
        check("t6_async_Y", vif_a.per_img_Y, 0);
        check("t6_async_cnt", vif_a.frame_cnt, 0);
        tick(); tick();
        rst_n = 1'b1;
        n = 0;
        while (nframe != f + 2 && n < 50) begin tick(); n++; end
        check("t6_restart_vsync", nframe, f + 2);
        n = 0;
        while (vif_a.per_frame_vsync && n < 400) begin tick(); n++; end
        check("t6_vsync_len", vs_len, 300);
        check("t6_cnt_before_end", vif_a.frame_cnt, 0);
        b0 = fd_cnt;
        wait_cnt_a(1, 13000, "t6_frame_cnt");
        check("t6_frame_done", fd_cnt - b0, 1);
        vif_a.enable = 1'b0;
        repeat (50) tick();
        check("href_equals_de", hd_bad, 0);
        $display("T6 reset recovery done, cycle %0d", cyc);

        // pixel table
        for (int i = 0; i < 20; i++) begin
            logic [7:0] act;
            if (vec[i].dut == 0)
                act = cap_a[fmap[vec[i].tag]][vec[i].y*100 + vec[i].x];
            else
                act = cap_b[vec[i].tag][vec[i].y*16 + vec[i].x];
            check($sformatf("pix_d%0d_t%0d_(%0d,%0d)", vec[i].dut, vec[i].tag, vec[i].x, vec[i].y),
                  act, vec[i].exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
